// File: rtl/multicycle_control_unit_if.sv
// Signal bundle between the LITE-16 multicycle control unit and the datapath/memory side.
// The control unit is the master; it issues strobes and memory requests.
interface multicycle_control_unit_if #(
  parameter int OP_W = 4
);
  logic            run;
  logic [OP_W-1:0] codeop;
  logic            mem_ready;
  logic            zero;
  logic            ri, cmp, mem, ld, st, jmp, fn;
  logic            ir_load, pc_inc, pc_load, mem_req, mem_we, reg_we;
  logic            halted, fault, illegal;
  logic [2:0]      state;

  modport master (
    input  run, codeop, mem_ready, zero,
    output ri, cmp, mem, ld, st, jmp, fn,
    output ir_load, pc_inc, pc_load, mem_req, mem_we, reg_we,
    output halted, fault, illegal, state
  );

  modport slave (
    output run, codeop, mem_ready, zero,
    input  ri, cmp, mem, ld, st, jmp, fn,
    input  ir_load, pc_inc, pc_load, mem_req, mem_we, reg_we,
    input  halted, fault, illegal, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// LITE-16 multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory
// ready handshake, a memory-wait timeout, and registered decode flags.
module multicycle_control_unit #(
  parameter int OP_W        = 4,
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // jz is internal only: it separates JZ from JMP, which share the jmp flag.
  typedef struct packed {
    logic ri, cmp, mem, ld, st, jmp, fn, jz;
  } dec_t;

  state_t          state_q;
  state_t          end_state;
  dec_t            dec_q;
  logic            fault_q, illegal_q;
  logic [TO_W-1:0] to_cnt, to_cnt_inc;
  logic [OP_W-1:0] op;
  logic            op_upper;
  logic            ir_load, pc_inc, pc_load, mem_req, mem_we, reg_we;

  assign op         = bus.codeop;
  assign op_upper   = |(op >> 4);
  assign to_cnt_inc = to_cnt + 1'b1;
  assign end_state  = bus.run ? S_FETCH : S_IDLE;

  function automatic dec_t decode(input logic [3:0] code);
    dec_t d;
    d = '0;
    case (code)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: d.fn = 1'b1;
      4'h8: begin d.fn  = 1'b1; d.ri  = 1'b1; end
      4'h9: d.cmp = 1'b1;
      4'hA: begin d.cmp = 1'b1; d.ri  = 1'b1; end
      4'hB: begin d.mem = 1'b1; d.ld  = 1'b1; end
      4'hC: begin d.mem = 1'b1; d.st  = 1'b1; end
      4'hD: d.jmp = 1'b1;
      4'hE: begin d.jmp = 1'b1; d.jz  = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dec_q     <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
      to_cnt    <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      to_cnt <= '0;
      case (state_q)
        S_IDLE: if (bus.run) state_q <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (bus.mem_ready) begin
            if (state_q == S_FETCH) state_q <= S_DECODE;
            else if (dec_q.ld)      state_q <= S_WB;
            else                    state_q <= end_state;
          end else if (to_cnt_inc == TO_W'(MEM_TIMEOUT)) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        S_DECODE: begin
          if (op_upper) begin
            dec_q     <= '0;
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            dec_q   <= decode(op[3:0]);
            state_q <= (op[3:0] == 4'hF) ? S_HALT : S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_q.fn)       state_q <= S_WB;
          else if (dec_q.mem) state_q <= S_MEM;
          else                state_q <= end_state;
        end
        S_WB:    state_q <= end_state;
        default: ;  // HALT and FAULT are left only through rst_n
      endcase
    end
  end

  always_comb begin
    // NOTE: every strobe gets a default before the case so no path can infer a latch.
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = bus.mem_ready;
      end
      S_EXEC: begin
        if (dec_q.jmp) begin
          pc_load = ~dec_q.jz | bus.zero;
          pc_inc  = dec_q.jz & ~bus.zero;
        end else begin
          pc_inc  = ~dec_q.fn & ~dec_q.mem;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_q.st;
        pc_inc  = bus.mem_ready & dec_q.st;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir_load = ir_load;
  assign bus.pc_inc  = pc_inc;
  assign bus.pc_load = pc_load;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.reg_we  = reg_we;
  assign bus.ri      = dec_q.ri;
  assign bus.cmp     = dec_q.cmp;
  assign bus.mem     = dec_q.mem;
  assign bus.ld      = dec_q.ld;
  assign bus.st      = dec_q.st;
  assign bus.jmp     = dec_q.jmp;
  assign bus.fn      = dec_q.fn;
  assign bus.halted  = (state_q == S_HALT) || (state_q == S_FAULT);
  assign bus.fault   = fault_q;
  assign bus.illegal = illegal_q;
  assign bus.state   = state_q;

endmodule
